// File: rtl/modbus_rtu_rxframer.sv
// -----------------------------------------------------------------------------
// modbus_rtu_rxframer
//   Frames MODBUS RTU requests out of a UART byte stream. Frame boundaries come
//   from line silence (1.5 / 3.5 character times measured in clk cycles). Each
//   received frame is buffered, CRC-checked and address-filtered. An accepted
//   frame is replayed to a consumer over a valid/ready stream with the two CRC
//   bytes stripped.
//
// Ports
//   clk        : reference clock, rising edge
//   reset      : asynchronous active-low reset
//   maddr      : own slave address
//   t15 / t35  : 1.5 / 3.5 character silence thresholds in clk cycles
//   din/ready  : received byte and its one-cycle strobe
//   rxerr      : one-cycle UART framing-error strobe
//   fdata/fvalid/fready/flast : outgoing frame byte stream
//   fbcast     : frame being delivered is a broadcast
//   frame_busy : a frame is being received, checked or delivered
//   frame_err  : one-cycle pulse when a frame is rejected
//   err_cnt    : saturating count of frame_err pulses
// -----------------------------------------------------------------------------
module modbus_rtu_rxframer #(
  parameter int DEPTH_LOG2 = 8,
  parameter int TMOSIZE    = 16,
  parameter bit BCAST_EN   = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         maddr,
  input  logic [TMOSIZE-1:0] t15,
  input  logic [TMOSIZE-1:0] t35,
  input  logic [7:0]         din,
  input  logic               ready,
  input  logic               rxerr,
  output logic [7:0]         fdata,
  output logic               fvalid,
  input  logic               fready,
  output logic               flast,
  output logic               fbcast,
  output logic               frame_busy,
  output logic               frame_err,
  output logic [7:0]         err_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LENW  = DEPTH_LOG2 + 1;
  localparam logic [LENW-1:0] LEN_FULL = LENW'(DEPTH);

  typedef enum logic [2:0] {SYNC, IDLE, RECV, GAP, CHECK, OUT} state_t;

  state_t                state_q, state_d;
  logic [TMOSIZE-1:0]    timer_q, timer_d;
  logic [LENW-1:0]       len_q, len_d;
  logic [15:0]           crc_q, crc_d;
  logic [7:0]            byte0_q, byte0_d;
  logic [DEPTH_LOG2-1:0] rd_idx_q, rd_idx_d;
  logic                  fvalid_q;
  logic                  fbcast_q, fbcast_d;
  logic                  frame_err_q, frame_err_d;
  logic [7:0]            err_cnt_q;

  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_waddr;
  logic [7:0]            mem [DEPTH];
  logic [7:0]            mem_rd_q;
  logic                  is_last;

  // One byte of reflected CRC-16 (poly 0xA001).
  function automatic logic [15:0] crc16_upd(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  // Silence timer: restarts on any line activity, saturates at all-ones.
  always_comb begin
    if (ready || rxerr) begin
      timer_d = '0;
    end else if (&timer_q) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + TMOSIZE'(1);
    end
  end

  // Index of the final payload byte is len-3 (CRC pair stripped).
  assign is_last = ({1'b0, rd_idx_q} == (len_q - LENW'(3)));

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    crc_d       = crc_q;
    byte0_d     = byte0_q;
    rd_idx_d    = '0;
    fbcast_d    = fbcast_q;
    frame_err_d = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = len_q[DEPTH_LOG2-1:0];

    case (state_q)
      SYNC: begin
        // Line activity already restarted the timer; wait for true silence.
        if (!ready && !rxerr && (timer_q >= t35)) begin
          state_d = IDLE;
        end
      end

      IDLE: begin
        if (rxerr) begin
          state_d = SYNC;
        end else if (ready) begin
          mem_we    = 1'b1;
          mem_waddr = '0;
          byte0_d   = din;
          len_d     = LENW'(1);
          crc_d     = crc16_upd(16'hFFFF, din);
          state_d   = RECV;
        end
      end

      RECV: begin
        if (rxerr) begin
          frame_err_d = 1'b1;
          state_d     = SYNC;
        end else if (ready) begin
          if (len_q == LEN_FULL) begin
            frame_err_d = 1'b1;
            state_d     = SYNC;
          end else begin
            mem_we = 1'b1;
            len_d  = len_q + LENW'(1);
            crc_d  = crc16_upd(crc_q, din);
          end
        end else if (timer_q >= t15) begin
          state_d = GAP;
        end
      end

      GAP: begin
        // A byte after 1.5 but before 3.5 char times breaks the frame.
        if (ready || rxerr) begin
          frame_err_d = 1'b1;
          state_d     = SYNC;
        end else if (timer_q >= t35) begin
          state_d = CHECK;
        end
      end

      CHECK: begin
        if ((len_q < LENW'(4)) || (crc_q != 16'h0000)) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else if ((byte0_q == maddr) || (BCAST_EN && (byte0_q == 8'h00))) begin
          fbcast_d = BCAST_EN && (byte0_q == 8'h00);
          state_d  = OUT;
        end else begin
          state_d = IDLE;
        end
      end

      OUT: begin
        if (ready) begin
          // New traffic while still replaying: abandon the stream.
          frame_err_d = 1'b1;
          fbcast_d    = 1'b0;
          state_d     = SYNC;
        end else if (fvalid_q && fready) begin
          if (is_last) begin
            fbcast_d = 1'b0;
            state_d  = IDLE;
          end else begin
            rd_idx_d = rd_idx_q + DEPTH_LOG2'(1);
          end
        end else begin
          rd_idx_d = rd_idx_q;
        end
      end

      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= SYNC;
      timer_q     <= '0;
      len_q       <= '0;
      crc_q       <= 16'hFFFF;
      byte0_q     <= 8'h00;
      rd_idx_q    <= '0;
      fvalid_q    <= 1'b0;
      fbcast_q    <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      len_q       <= len_d;
      crc_q       <= crc_d;
      byte0_q     <= byte0_d;
      rd_idx_q    <= rd_idx_d;
      fvalid_q    <= (state_d == OUT);
      fbcast_q    <= fbcast_d;
      frame_err_q <= frame_err_d;
      if (frame_err_d && (err_cnt_q != 8'hFF)) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  // Frame buffer. The read address is the next-cycle byte index, so the
  // registered read data always matches rd_idx_q while streaming and stays
  // put during back-pressure.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= din;
    end
    mem_rd_q <= mem[rd_idx_d];
  end

  assign fvalid     = fvalid_q;
  assign fdata      = fvalid_q ? mem_rd_q : 8'h00;
  assign flast      = fvalid_q && is_last;
  assign fbcast     = fbcast_q;
  assign frame_busy = (state_q == RECV) || (state_q == GAP) ||
                      (state_q == CHECK) || (state_q == OUT);
  assign frame_err  = frame_err_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_modbus_rtu_rxframer.sv
`timescale 1ns/1ps
module tb_modbus_rtu_rxframer;

  localparam int DL2   = 4;
  localparam int DEPTH = 1 << DL2;
  localparam int TW    = 16;
  localparam int T15   = 10;
  localparam int T35   = 20;

  typedef logic [7:0] byte_q_t [$];

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    maddr;
  logic [TW-1:0] t15, t35;
  logic [7:0]    din;
  logic          ready, rxerr;
  logic [7:0]    fdata;
  logic          fvalid, fready, flast, fbcast;
  logic          frame_busy, frame_err;
  logic [7:0]    err_cnt;

  modbus_rtu_rxframer #(.DEPTH_LOG2(DL2), .TMOSIZE(TW), .BCAST_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .maddr(maddr), .t15(t15), .t35(t35),
    .din(din), .ready(ready), .rxerr(rxerr),
    .fdata(fdata), .fvalid(fvalid), .fready(fready), .flast(flast),
    .fbcast(fbcast), .frame_busy(frame_busy), .frame_err(frame_err),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  logic [9:0] exp_q [$];   // {bcast, last, data}
  int         exp_err = 0;
  int         obs_err = 0;
  bit         rand_fready = 1'b1;
  bit         force_low = 1'b0;

  // ---------------- reference model ----------------
  // Bit-serial CRC-16/MODBUS over the first cnt bytes.
  function automatic logic [15:0] model_crc(input byte_q_t q, input int cnt);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    for (int i = 0; i < cnt; i++) begin
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ q[i][j];
        c  = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    end
    return c;
  endfunction

  function automatic byte_q_t with_crc(input byte_q_t p);
    byte_q_t q;
    logic [15:0] c;
    q = p;
    c = model_crc(p, p.size());
    q.push_back(c[7:0]);
    q.push_back(c[15:8]);
    return q;
  endfunction

  // Outcome of a frame received cleanly on an idle line.
  task automatic model_frame(input byte_q_t q);
    int n;
    logic [15:0] c;
    n = q.size();
    if (n > DEPTH || n < 4) begin
      exp_err++;
      return;
    end
    c = model_crc(q, n - 2);
    if (c != {q[n-1], q[n-2]}) begin
      exp_err++;
      return;
    end
    if (q[0] == maddr || q[0] == 8'h00) begin
      for (int i = 0; i <= n - 3; i++) exp_q.push_back({(q[0] == 8'h00), (i == n - 3), q[i]});
    end
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    ready = 1'b1; din = b;
    @(posedge clk); #1;
    ready = 1'b0;
  endtask

  task automatic strobe_rxerr();
    rxerr = 1'b1;
    @(posedge clk); #1;
    rxerr = 1'b0;
  endtask

  task automatic send_frame(input byte_q_t q, input int sp, input int gap_at, input int gap_len);
    for (int i = 0; i < q.size(); i++) begin
      send_byte(q[i]);
      if (i < q.size() - 1) idle(((i == gap_at) ? gap_len : sp) - 1);
    end
  endtask

  task automatic wait_fvalid(input string name);
    int k;
    k = 0;
    while (!fvalid && k < 100) begin @(posedge clk); #1; k++; end
    chk({name, "_fvalid_seen"}, {31'd0, fvalid}, 32'd1);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 3000) begin @(posedge clk); #1; k++; end
    chk({name, "_beats_left"}, exp_q.size(), 32'd0);
    exp_q.delete();
    idle(3);
    chk({name, "_err_pulses"}, obs_err, exp_err);
    chk({name, "_err_cnt"}, {24'd0, err_cnt}, (exp_err > 255) ? 32'd255 : exp_err);
    chk({name, "_fvalid_idle"}, {31'd0, fvalid}, 32'd0);
    chk({name, "_busy_idle"}, {31'd0, frame_busy}, 32'd0);
  endtask

  // ---------------- consumer ----------------
  initial begin
    fready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (force_low)        fready = 1'b0;
      else if (rand_fready) fready = ($urandom_range(0, 3) != 0);
      else                  fready = 1'b1;
    end
  end

  // ---------------- compare process ----------------
  initial begin : cmp
    logic [9:0] e;
    logic [7:0] p_data;
    logic       p_last, p_bcast, p_stall, p_err;
    p_stall = 1'b0; p_err = 1'b0; p_data = 8'h00; p_last = 1'b0; p_bcast = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (frame_err) begin
          obs_err++;
          $display("frame_err pulse #%0d at %0t", obs_err, $time);
          total++;
          if (p_err) begin bad++; $display("FAIL frame_err_width: got 2+ cycles, required 1"); end
        end
        if (fvalid && p_stall) begin
          total++;
          if ({fdata, flast, fbcast} !== {p_data, p_last, p_bcast}) begin
            bad++;
            $display("FAIL stall_stable: got %02h/%0b/%0b, required %02h/%0b/%0b",
                     fdata, flast, fbcast, p_data, p_last, p_bcast);
          end
        end
        if (fvalid && fready) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL beat_unexpected: got %02h, required no beat", fdata);
          end else begin
            e = exp_q.pop_front();
            $display("beat data=%02h last=%0b bcast=%0b", fdata, flast, fbcast);
            if ({fbcast, flast, fdata} !== e) begin
              bad++;
              $display("FAIL beat: got %03h, required %03h", {fbcast, flast, fdata}, e);
            end
          end
        end
        p_stall = fvalid && !fready;
        p_err   = frame_err;
        p_data  = fdata; p_last = flast; p_bcast = fbcast;
      end else begin
        p_stall = 1'b0; p_err = 1'b0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : main
    byte_q_t f39, fbad, fb, q, p;
    int kind, n, sp, pos;
    logic [7:0] b;

    reset = 1'b0; maddr = 8'h01; t15 = TW'(T15); t35 = TW'(T35);
    din = 8'h00; ready = 1'b0; rxerr = 1'b0;
    idle(3);
    chk("rst_fvalid", {31'd0, fvalid}, 32'd0);
    chk("rst_fdata", {24'd0, fdata}, 32'd0);
    chk("rst_flast", {31'd0, flast}, 32'd0);
    chk("rst_fbcast", {31'd0, fbcast}, 32'd0);
    chk("rst_busy", {31'd0, frame_busy}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    chk("rst_errcnt", {24'd0, err_cnt}, 32'd0);
    reset = 1'b1;
    idle(T35 + 5);

    // Pin the model CRC against well-known frames.
    f39 = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
    chk("model_crc_0103", {16'd0, model_crc(f39, 6)}, 32'h0A84);
    q = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03};
    chk("model_crc_0106", {16'd0, model_crc(q, 6)}, 32'h0B98);

    // Reference read request, literal expectations.
    $display("frame: read request to own address");
    exp_q = '{10'h001, 10'h003, 10'h000, 10'h000, 10'h000, 10'h101};
    send_frame(f39, 5, -1, 0);
    idle(T35 + 5);
    drain("own_addr");

    // Other slave's address: silently dropped.
    $display("frame: addressed to another slave");
    maddr = 8'h02;
    send_frame(f39, 5, -1, 0);
    idle(T35 + 5);
    drain("other_addr");
    maddr = 8'h01;

    // Corrupted CRC.
    $display("frame: bad CRC");
    fbad = f39; fbad[7] = 8'h0B;
    exp_err = exp_err + 1;
    send_frame(fbad, 5, -1, 0);
    idle(T35 + 5);
    drain("bad_crc");
    chk("bad_crc_errcnt_lit", {24'd0, err_cnt}, 32'd1);

    // Inter-character gap of 15 cycles between bytes 3 and 4.
    $display("frame: mid-frame gap");
    exp_err = exp_err + 1;
    send_frame(f39, 5, 2, 15);
    idle(T35 + 5);
    exp_q = '{10'h001, 10'h003, 10'h000, 10'h000, 10'h000, 10'h101};
    send_frame(f39, 5, -1, 0);
    idle(T35 + 5);
    drain("gap_then_clean");

    // Broadcast with consumer stalled for 10 cycles.
    $display("frame: broadcast with stall");
    fb = with_crc('{8'h00, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03});
    exp_q = '{10'h200, 10'h206, 10'h200, 10'h201, 10'h200, 10'h303};
    force_low = 1'b1;
    send_frame(fb, 5, -1, 0);
    idle(T35);
    wait_fvalid("bcast");
    idle(10);
    chk("bcast_stall_fdata", {24'd0, fdata}, 32'h00);
    chk("bcast_stall_fbcast", {31'd0, fbcast}, 32'd1);
    force_low = 1'b0;
    drain("bcast");

    // Randomized frames.
    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(0, 10);
      sp   = $urandom_range(1, T15 - 2);
      n    = $urandom_range(2, 12);
      p.delete();
      case ($urandom_range(0, 2))
        0:       b = 8'h01;
        1:       b = 8'h00;
        default: b = 8'($urandom_range(2, 255));
      endcase
      p.push_back(b);
      for (int i = 1; i < n; i++) p.push_back(8'($urandom_range(0, 255)));
      q = with_crc(p);
      $display("frame: random kind=%0d len=%0d addr=%02h", kind, q.size(), q[0]);
      if (kind <= 4) begin
        model_frame(q);
        send_frame(q, sp, -1, 0);
      end else if (kind == 5) begin
        pos = $urandom_range(0, q.size() - 1);
        q[pos] = q[pos] ^ 8'($urandom_range(1, 255));
        model_frame(q);
        send_frame(q, sp, -1, 0);
      end else if (kind == 6) begin
        while (q.size() > 3 || q.size() > $urandom_range(1, 3)) void'(q.pop_back());
        model_frame(q);
        send_frame(q, sp, -1, 0);
      end else if (kind == 7) begin
        exp_err++;
        send_frame(q, sp, $urandom_range(0, q.size() - 2), $urandom_range(T15 + 3, T35 - 3));
      end else if (kind == 8) begin
        exp_err++;
        pos = $urandom_range(1, q.size() - 1);
        for (int i = 0; i < pos; i++) begin send_byte(q[i]); idle(sp - 1); end
        strobe_rxerr();
        for (int i = pos; i < q.size(); i++) begin idle(sp - 1); send_byte(q[i]); end
      end else if (kind == 9) begin
        p.delete();
        for (int i = 0; i < $urandom_range(DEPTH + 1, DEPTH + 4); i++) p.push_back(8'($urandom_range(0, 255)));
        p[0] = 8'h01;
        model_frame(p);
        send_frame(p, sp, -1, 0);
      end else begin
        strobe_rxerr();
        idle(T35 + 5);
        model_frame(q);
        send_frame(q, sp, -1, 0);
      end
      idle(T35 + 5 + $urandom_range(0, 5));
      drain("random");
    end

    // Overrun: new byte while the frame is being delivered.
    $display("frame: overrun during delivery");
    force_low = 1'b1;
    send_frame(f39, 3, -1, 0);
    idle(T35);
    wait_fvalid("overrun");
    exp_err++;
    send_byte(8'h55);
    chk("overrun_fvalid_drop", {31'd0, fvalid}, 32'd0);
    force_low = 1'b0;
    idle(T35 + 5);
    drain("overrun");

    // Reset while the third byte is on offer.
    $display("frame: reset during delivery");
    rand_fready = 1'b0;
    model_frame(f39);
    send_frame(f39, 5, -1, 0);
    idle(T35);
    wait_fvalid("rst_out");
    idle(2);
    reset = 1'b0;
    #1;
    chk("rst_out_fvalid", {31'd0, fvalid}, 32'd0);
    chk("rst_out_errcnt", {24'd0, err_cnt}, 32'd0);
    exp_q.delete(); exp_err = 0; obs_err = 0;
    idle(3);
    reset = 1'b1;
    rand_fready = 1'b1;
    idle(5);
    send_frame(f39, 5, -1, 0);   // arrives before the line has been silent long enough
    idle(T35 + 5);
    drain("rst_early");
    model_frame(f39);
    send_frame(f39, 5, -1, 0);
    idle(T35 + 5);
    drain("rst_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
